// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue stage: opcode constants, FSM state,
// instruction field positions and the per-word decode helper.
package decode_pkg;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } state_t;

  typedef struct packed {
    logic        use_rs;
    logic        use_rt;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] imm;
  } dec_t;

  // Unrecognised opcodes fall through as a NOP: no sources, no destination.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [15:0] imm16;
    op    = w[OPC_HI:OPC_LO];
    rt    = w[RT_HI:RT_LO];
    rd    = w[RD_HI:RD_LO];
    imm16 = w[IMM_HI:IMM_LO];
    d     = '0;
    case (op)
      OP_RTYPE: begin
        d.use_rs    = 1'b1;
        d.use_rt    = 1'b1;
        d.dest      = rd;
        d.reg_write = (rd != '0);
      end
      OP_ADDI, OP_SLTI, OP_LW: begin
        d.use_rs    = 1'b1;
        d.dest      = rt;
        d.reg_write = (rt != '0);
        d.imm       = {{16{imm16[15]}}, imm16};
      end
      OP_ANDI, OP_ORI: begin
        d.use_rs    = 1'b1;
        d.dest      = rt;
        d.reg_write = (rt != '0);
        d.imm       = {16'h0000, imm16};
      end
      OP_SW, OP_BEQ: begin
        d.use_rs    = 1'b1;
        d.use_rt    = 1'b1;
        d.imm       = {{16{imm16[15]}}, imm16};
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy scoreboard: one pending-write bit per architectural register.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_reg,
  input  logic       clr_en,
  input  logic [4:0] clr_reg,
  input  logic [4:0] query1,
  input  logic [4:0] query2,
  output logic       busy1,
  output logic       busy2
);

  logic [31:0] busy;
  logic [31:0] busy_nx;

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    busy_nx = busy;
    if (clr_en) busy_nx[clr_reg] = 1'b0;
    if (set_en) busy_nx[set_reg] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nx;
  end

  assign busy1 = busy[query1];
  assign busy2 = busy[query2];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: holds one fetched word, stalls on scoreboard hazards and
// presents decoded operands in a registered valid/ready output slot.
module decode_issue
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        wbValid,
  input  logic [4:0]  wbReg,
  output logic        issueValid,
  input  logic        issueReady,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [31:0] imm,
  output logic [4:0]  destReg,
  output logic        regWrite,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  state_t      state;
  logic [31:0] ir;
  dec_t        dec;
  logic        busy1;
  logic        busy2;
  logic        hazard;
  logic        advance;
  logic        accept;

  assign dec      = decode(ir);
  assign readReg1 = ir[RS_HI:RS_LO];
  assign readReg2 = ir[RT_HI:RT_LO];

  assign hazard  = (dec.use_rs && busy1) || (dec.use_rt && busy2);
  assign advance = (state == ST_HELD) && !hazard && (!issueValid || issueReady);

  // Ready is combinational so a new word can enter in the same cycle the held one leaves.
  assign instrReady = !reset && ((state == ST_IDLE) || advance);
  assign accept     = instrValid && instrReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ir    <= instr;
            state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (accept) ir <= instr;
          else if (advance) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issueValid <= 1'b0;
      opA        <= '0;
      opB        <= '0;
      imm        <= '0;
      destReg    <= '0;
      regWrite   <= 1'b0;
      opcode     <= '0;
      funct      <= '0;
    end else if (advance) begin
      issueValid <= 1'b1;
      opA        <= dec.use_rs ? readData1 : '0;
      opB        <= dec.use_rt ? readData2 : '0;
      imm        <= dec.imm;
      destReg    <= dec.dest;
      regWrite   <= dec.reg_write;
      opcode     <= ir[OPC_HI:OPC_LO];
      funct      <= ir[FN_HI:FN_LO];
    end else if (issueReady) begin
      issueValid <= 1'b0;
    end
  end

  decode_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (advance && dec.reg_write),
    .set_reg (dec.dest),
    .clr_en  (wbValid),
    .clr_reg (wbReg),
    .query1  (readReg1),
    .query2  (readReg2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have these ports (clock and reset first): clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have: instr in 32, fetched MIPS word; instrValid in 1; instrReady out 1.
REQ-003 SHALL have: readReg1 out 5, readReg2 out 5, register-file read addresses; readData1 in 32, readData2 in 32, same-cycle combinational read data.
REQ-004 SHALL have: wbValid in 1, wbReg in 5, register-file write completion.
REQ-005 SHALL have: issueValid out 1, issueReady in 1, opA out 32, opB out 32, imm out 32, destReg out 5, regWrite out 1, opcode out 6, funct out 6.

Function
REQ-006 SHALL use fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm16[15:0].
REQ-007 SHALL decode the following classes:
- opcode 0x00 (R-type): read rs and rt; dest rd; regWrite = (rd != 0).
- 0x08 addi, 0x0A slti, 0x23 lw: read rs; dest rt; imm16 sign-extended.
- 0x0C andi, 0x0D ori: read rs; dest rt; imm16 zero-extended.
- 0x2B sw, 0x04 beq: read rs and rt; imm16 sign-extended; regWrite = 0.
- Any other opcode: NOP; no sources read; regWrite = 0; still issued.
REQ-008 SHALL hold the accepted word in an instruction register (IR); readReg1 = IR.rs and readReg2 = IR.rt at all times.
REQ-009 SHALL keep a 32-bit scoreboard busy[31:0]; busy[0] SHALL always read 0.
REQ-010 SHALL detect a hazard when a source register used by IR has its busy bit set; unused sources SHALL be ignored.
REQ-011 SHALL run an FSM with two states:
- IDLE: IR empty; instrReady = 1.
- HELD: IR full; instrReady = 1 only in a cycle in which IR advances.
REQ-012 IR SHALL advance when the state is HELD, there is no hazard, and (issueValid = 0 or issueReady = 1).
REQ-013 On advance, the output register SHALL load opA = readData1, opB = readData2 (0 for unused sources), imm, destReg, regWrite, opcode and funct; issueValid SHALL be 1 in the next cycle.
REQ-014 Latency SHALL be 2 cycles: a word accepted at edge N with no hazard and no backpressure gives issueValid = 1 after edge N+1. One instruction per cycle SHALL be sustained.
REQ-015 An instrValid & instrReady handshake in the same cycle as an advance SHALL reload IR; state stays HELD. With no new word, the FSM SHALL return to IDLE.
REQ-016 While issueValid = 1 and issueReady = 0, all output fields SHALL hold stable.
REQ-017 On advance with regWrite = 1, busy[dest] SHALL be set at that edge.
REQ-018 When wbValid = 1, busy[wbReg] SHALL clear at that edge; wbReg = 0 SHALL be ignored.
REQ-019 If a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-020 A hazard SHALL not be bypassed: a reader stalls through the wbValid cycle and advances at the earliest in the following cycle.

Reset
REQ-021 With reset = 1 at an edge, the block SHALL enter IDLE and clear busy and IR.
REQ-022 Reset SHALL zero issueValid, opA, opB, imm, destReg, regWrite, opcode and funct.
REQ-023 instrReady SHALL be 0 while reset is asserted and 1 in the first cycle after.
REQ-024 Reset mid-stall SHALL discard the held instruction and all pending busy bits.

Structure
REQ-025 Package decode_pkg SHALL hold:
- the opcode constants OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ;
- the FSM state enum;
- the field bit-position constants.
REQ-026 The scoreboard SHALL be a sub-module decode_scoreboard with these ports:
- set (enable, register);
- clear (enable, register);
- two query registers;
- two busy outputs.

Verification
REQ-027 Reset, then addi r7,r0,5 (0x20070005) -> issueValid after 2 edges; destReg = 7, regWrite = 1, imm = 0x00000005, busy[7] = 1.
REQ-028 Issue add r13,r1,r3 with r1 = 0xdddddddd, r3 = 0xaaaaaaaa -> opA = 0xdddddddd, opB = 0xaaaaaaaa, destReg = 13.
REQ-029 Issue addi r7 then sub r8,r7,r2 -> sub stalls with instrReady = 0; pulse wbValid with wbReg = 7 -> sub issues in the cycle after the pulse.
REQ-030 Hold issueReady = 0 for 3 cycles with an issued andi imm = 0x8000 -> outputs stable; imm = 0x00008000 (zero-extended); lw imm 0x8000 -> 0xffff8000.
REQ-031 wbValid with wbReg = 11 in the same cycle as an advance setting busy[11] -> busy[11] = 1; R-type with rd = 0 -> regWrite = 0, busy[0] = 0.
REQ-032 Assert reset during a stall -> next cycle issueValid = 0, busy = 0, instrReady = 1.
